// File: rtl/ft64_regfile_wb_sched.sv
// ft64_regfile_wb_sched
//   Write-back scheduler for the 2-write/6-read register file. Commit
//   results arrive up to two per cycle, with the older one on slot 0. They
//   are queued in a small FIFO. Up to two entries per cycle drain onto the
//   registered write ports, in program order. Port 1 always carries the
//   younger write, because the register file lands port 1 after port 0.
//
// Ports
//   clk           system clock
//   rst_n         synchronous active-low reset
//   in0_*/in1_*   commit slots (v, wa, we, d); slot 0 is older
//   in_rdy        both slots may be accepted this cycle
//   hold          suppress issue to the register file
//   wr0/wr1       write strobes
//   we0/we1       byte enables
//   wa0/wa1       write addresses
//   i0/i1         write data
//   count         occupied FIFO entries
//   empty         count == 0
module ft64_regfile_wb_sched #(
  parameter int WID   = 64,
  parameter int RBIT  = 11,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in0_v,
  input  logic [RBIT:0]              in0_wa,
  input  logic [WID/8-1:0]           in0_we,
  input  logic [WID-1:0]             in0_d,
  input  logic                       in1_v,
  input  logic [RBIT:0]              in1_wa,
  input  logic [WID/8-1:0]           in1_we,
  input  logic [WID-1:0]             in1_d,
  output logic                       in_rdy,
  input  logic                       hold,
  output logic                       wr0,
  output logic                       wr1,
  output logic [WID/8-1:0]           we0,
  output logic [WID/8-1:0]           we1,
  output logic [RBIT:0]              wa0,
  output logic [RBIT:0]              wa1,
  output logic [WID-1:0]             i0,
  output logic [WID-1:0]             i1,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = WID / 8;

  typedef struct packed {
    logic [RBIT:0]   wa;
    logic [BW-1:0]   we;
    logic [WID-1:0]  d;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] headPtr;
  logic [PW-1:0] tailPtr;
  logic [PW-1:0] headNext;
  logic [PW-1:0] tailSecond;
  logic          keep0;
  logic          keep1;
  logic [CW-1:0] pushNum;
  logic [CW-1:0] popNum;

  // Accept only when there is room for a full pair. This is judged from
  // the count at the start of the cycle, so it never depends on this
  // cycle's dequeue. Reset forces it low.
  assign in_rdy = rst_n & (count <= CW'(DEPTH - 2));
  assign empty  = (count == '0);

  // Writes to r0 are dropped because r0 is hardwired. All-zero byte masks
  // are dropped because they are no-ops. When only slot 1 survives, it
  // takes the single tail position. Up to two entries pop per cycle,
  // taken only from what was already queued, so there is no bypass from
  // input to output.
  always_comb begin
    keep0      = in_rdy & in0_v & (in0_wa[4:0] != 5'd0) & (|in0_we);
    keep1      = in_rdy & in1_v & (in1_wa[4:0] != 5'd0) & (|in1_we);
    pushNum    = CW'(keep0) + CW'(keep1);
    popNum     = '0;
    if (!hold)
      popNum = (count >= CW'(2)) ? CW'(2) : count;
    tailSecond = tailPtr + PW'(keep0);
    headNext   = headPtr + PW'(1);
  end

  // Storage needs no reset: the pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (keep0)
      mem[tailPtr] <= '{wa: in0_wa, we: in0_we, d: in0_d};
    if (keep1)
      mem[tailSecond] <= '{wa: in1_wa, we: in1_we, d: in1_d};
  end

  // Pointer and count bookkeeping together with the registered write
  // ports. The head entry goes to port 0 and the next entry to port 1.
  // Any port with nothing to issue, including every port under hold, is
  // driven fully to zero. The pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
      wr0     <= 1'b0;
      wr1     <= 1'b0;
      we0     <= '0;
      we1     <= '0;
      wa0     <= '0;
      wa1     <= '0;
      i0      <= '0;
      i1      <= '0;
    end else begin
      headPtr <= headPtr + PW'(popNum);
      tailPtr <= tailPtr + PW'(pushNum);
      count   <= count + pushNum - popNum;
      wr0     <= 1'b0;
      wr1     <= 1'b0;
      we0     <= '0;
      we1     <= '0;
      wa0     <= '0;
      wa1     <= '0;
      i0      <= '0;
      i1      <= '0;
      if (popNum >= CW'(1)) begin
        wr0 <= 1'b1;
        we0 <= mem[headPtr].we;
        wa0 <= mem[headPtr].wa;
        i0  <= mem[headPtr].d;
      end
      if (popNum >= CW'(2)) begin
        wr1 <= 1'b1;
        we1 <= mem[headNext].we;
        wa1 <= mem[headNext].wa;
        i1  <= mem[headNext].d;
      end
    end
  end

endmodule

// File: tb/tb_ft64_regfile_wb_sched.sv
// tb_ft64_regfile_wb_sched
//   Directed bench for the write-back scheduler. The expected values are
//   hand-computed for the directed cases. A small queue model supplies the
//   expected values for the continuous-traffic run.
module tb_ft64_regfile_wb_sched;

  logic        clk;
  logic        rst_n;
  logic        in0_v;
  logic [11:0] in0_wa;
  logic [7:0]  in0_we;
  logic [63:0] in0_d;
  logic        in1_v;
  logic [11:0] in1_wa;
  logic [7:0]  in1_we;
  logic [63:0] in1_d;
  logic        in_rdy;
  logic        hold;
  logic        wr0;
  logic        wr1;
  logic [7:0]  we0;
  logic [7:0]  we1;
  logic [11:0] wa0;
  logic [11:0] wa1;
  logic [63:0] i0;
  logic [63:0] i1;
  logic [2:0]  count;
  logic        empty;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [11:0] wa;
    logic [7:0]  we;
    logic [63:0] d;
  } entry_t;

  entry_t modelQ[$];

  ft64_regfile_wb_sched dut (
    .clk(clk), .rst_n(rst_n),
    .in0_v(in0_v), .in0_wa(in0_wa), .in0_we(in0_we), .in0_d(in0_d),
    .in1_v(in1_v), .in1_wa(in1_wa), .in1_we(in1_we), .in1_d(in1_d),
    .in_rdy(in_rdy), .hold(hold),
    .wr0(wr0), .wr1(wr1), .we0(we0), .we1(we1),
    .wa0(wa0), .wa1(wa1), .i0(i0), .i1(i1),
    .count(count), .empty(empty)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [11:0] a0,
                               input logic [7:0] e0, input logic [63:0] d0,
                               input logic v1, input logic [11:0] a1,
                               input logic [7:0] e1, input logic [63:0] d1);
    in0_v = v0; in0_wa = a0; in0_we = e0; in0_d = d0;
    in1_v = v1; in1_wa = a1; in1_we = e1; in1_d = d1;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 12'h0, 8'h0, 64'h0, 1'b0, 12'h0, 8'h0, 64'h0);
  endtask

  // Advance one edge. Outputs are sampled and inputs changed 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of the model: predict in_rdy, issue up to two queued
  // entries, queue the survivors, then compare every output port.
  task automatic modelCycle(input logic v0, input logic [11:0] a0,
                            input logic [7:0] e0, input logic [63:0] d0,
                            input logic v1, input logic [11:0] a1,
                            input logic [7:0] e1, input logic [63:0] d1);
    entry_t exp0;
    entry_t exp1;
    int     popN;
    logic   rdy;
    applyStimulus(v0, a0, e0, d0, v1, a1, e1, d1);
    rdy  = (modelQ.size() <= 2);
    checkOutput("m_rdy", in_rdy, rdy);
    popN = (modelQ.size() >= 2) ? 2 : modelQ.size();
    exp0 = '0;
    exp1 = '0;
    if (popN >= 1) exp0 = modelQ.pop_front();
    if (popN >= 2) exp1 = modelQ.pop_front();
    if (rdy && v0 && a0[4:0] != 5'd0 && e0 != 8'h0) modelQ.push_back('{a0, e0, d0});
    if (rdy && v1 && a1[4:0] != 5'd0 && e1 != 8'h0) modelQ.push_back('{a1, e1, d1});
    tick();
    checkOutput("m_wr0", wr0, popN >= 1);
    checkOutput("m_wa0", wa0, exp0.wa);
    checkOutput("m_we0", we0, exp0.we);
    checkOutput("m_i0", i0, exp0.d);
    checkOutput("m_wr1", wr1, popN >= 2);
    checkOutput("m_wa1", wa1, exp1.wa);
    checkOutput("m_we1", we1, exp1.we);
    checkOutput("m_i1", i1, exp1.d);
    checkOutput("m_count", count, modelQ.size());
  endtask

  initial begin
    rst_n = 1'b0;
    hold  = 1'b0;
    idleInputs();

    // Reset state
    tick();
    tick();
    checkOutput("rst_count", count, 0);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_rdy", in_rdy, 0);
    checkOutput("rst_wr0", wr0, 0);
    checkOutput("rst_wr1", wr1, 0);
    rst_n = 1'b1;
    #1;
    checkOutput("rdy_after_rst", in_rdy, 1);

    // 1: single write, two-edge latency
    applyStimulus(1'b1, 12'h005, 8'hFF, 64'h1122334455667788,
                  1'b0, 12'h0, 8'h0, 64'h0);
    tick();
    idleInputs();
    checkOutput("t1_count", count, 1);
    checkOutput("t1_nobypass", wr0, 0);
    tick();
    checkOutput("t1_wr0", wr0, 1);
    checkOutput("t1_wa0", wa0, 12'h005);
    checkOutput("t1_we0", we0, 8'hFF);
    checkOutput("t1_i0", i0, 64'h1122334455667788);
    checkOutput("t1_wr1", wr1, 0);
    checkOutput("t1_empty", empty, 1);
    tick();
    checkOutput("t1_oneshot", wr0, 0);

    // 2: same address on both slots, younger lands on port 1
    applyStimulus(1'b1, 12'h003, 8'hFF, 64'hAAAA_AAAA_AAAA_AAAA,
                  1'b1, 12'h003, 8'h0F, 64'hBBBB_BBBB_BBBB_BBBB);
    tick();
    idleInputs();
    checkOutput("t2_count", count, 2);
    tick();
    checkOutput("t2_wr0", wr0, 1);
    checkOutput("t2_i0", i0, 64'hAAAA_AAAA_AAAA_AAAA);
    checkOutput("t2_wr1", wr1, 1);
    checkOutput("t2_wa1", wa1, 12'h003);
    checkOutput("t2_we1", we1, 8'h0F);
    checkOutput("t2_i1", i1, 64'hBBBB_BBBB_BBBB_BBBB);
    checkOutput("t2_count0", count, 0);

    // 3: r0 target and zero byte mask are both filtered
    applyStimulus(1'b1, 12'h020, 8'hFF, 64'h1, 1'b1, 12'h007, 8'h00, 64'h2);
    tick();
    idleInputs();
    checkOutput("t3_count", count, 0);
    checkOutput("t3_empty", empty, 1);
    tick();
    checkOutput("t3_wr0", wr0, 0);
    checkOutput("t3_wr1", wr1, 0);

    // 4: fill under hold (pointers start at 3 so they wrap), then drain
    hold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 12'(12'h011 + 2 * k), 8'hFF, 64'(64'hC00 + 2 * k),
                    1'b1, 12'(12'h012 + 2 * k), 8'hFF, 64'(64'hC01 + 2 * k));
      #1;
      checkOutput("t4_rdy", in_rdy, k < 2);
      tick();
      checkOutput("t4_count", count, (k == 0) ? 2 : 4);
      checkOutput("t4_hold_wr0", wr0, 0);
    end
    idleInputs();
    hold = 1'b0;
    tick();
    checkOutput("t4_d1_wa0", wa0, 12'h011);
    checkOutput("t4_d1_wa1", wa1, 12'h012);
    checkOutput("t4_d1_count", count, 2);
    tick();
    checkOutput("t4_d2_wr0", wr0, 1);
    checkOutput("t4_d2_i0", i0, 64'hC02);
    checkOutput("t4_d2_i1", i1, 64'hC03);
    checkOutput("t4_d2_count", count, 0);
    tick();
    checkOutput("t4_idle_wr0", wr0, 0);

    // 5: continuous traffic against the queue model
    for (int i = 0; i < 20; i++) begin
      modelCycle((i % 3) != 2,
                 (i % 5 == 0) ? 12'h040 : 12'(12'h100 + i),
                 8'(i * 37 + 1),
                 {32'(32'hA0A0_0000 + i), 32'(i)},
                 (i % 4) != 1,
                 12'(12'h200 + i),
                 (i % 7 == 3) ? 8'h00 : (8'hF0 ^ 8'(i)),
                 64'(64'hB000_0000_0000_0000 | 64'(i)));
    end
    for (int i = 0; i < 3; i++)
      modelCycle(1'b0, 12'h0, 8'h0, 64'h0, 1'b0, 12'h0, 8'h0, 64'h0);
    checkOutput("t5_drained", count, 0);

    // 6: reset while entries are queued and a strobe is active
    hold = 1'b1;
    applyStimulus(1'b1, 12'h031, 8'hFF, 64'hD1, 1'b1, 12'h032, 8'hFF, 64'hD2);
    tick();
    applyStimulus(1'b1, 12'h033, 8'hFF, 64'hD3, 1'b0, 12'h0, 8'h0, 64'h0);
    tick();
    idleInputs();
    checkOutput("t6_count3", count, 3);
    hold = 1'b0;
    tick();
    checkOutput("t6_wr0", wr0, 1);
    checkOutput("t6_count1", count, 1);
    rst_n = 1'b0;
    applyStimulus(1'b1, 12'h034, 8'hFF, 64'hD4, 1'b1, 12'h035, 8'hFF, 64'hD5);
    #1;
    checkOutput("t6_rdy_rst", in_rdy, 0);
    tick();
    idleInputs();
    checkOutput("t6_wr0_rst", wr0, 0);
    checkOutput("t6_wr1_rst", wr1, 0);
    checkOutput("t6_count_rst", count, 0);
    rst_n = 1'b1;
    tick();
    checkOutput("t6_stale0", wr0, 0);
    tick();
    checkOutput("t6_stale1", wr0, 0);
    checkOutput("t6_empty", empty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
